btn_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the block/character controller. It takes the four raw board push-buttons, which are asynchronous and bouncy, and synchronizes and debounces each one on the fast board clock. It produces clean held-direction levels (`up`, `down`, `left`, `right`) for the controller. It also produces sticky press pulses that persist until the controller's slow game tick has sampled them, so no press is lost across the clock-rate gap.

---
 rtl/game_pkg.sv | 26 ++
 rtl/btn_debounce_ch.sv | 114 +++++++++++
 rtl/btn_conditioner.sv | 70 +++++++
 tb/tb_btn_conditioner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game input path.
//   btn_state_e        : per-button debounce FSM state encoding
//   DIR_U/D/L/R        : bit index of each direction in direction vectors
//   DB_CYCLES_DEFAULT  : default debounce qualification length (5 ms @ 100 MHz)
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_e;

    localparam int DIR_U = 0;
    localparam int DIR_D = 1;
    localparam int DIR_L = 2;
    localparam int DIR_R = 3;

    localparam int NUM_DIRS = 4;

    localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One push-button channel: 2-flop synchronizer, debounce FSM with a
// qualification counter, and a sticky press flag held until the slow game
// tick has had a chance to see it.
//   clk         : board clock
//   rst         : asynchronous active-high reset
//   btn_i       : raw asynchronous button, active-high
//   game_tick_i : one-cycle strobe where the slow domain samples its inputs
//   level       : debounced held level (high in HELD or REL_CHK)
//   press_p     : sticky press flag, cleared by game_tick_i
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import game_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic game_tick_i,
    output logic level,
    output logic press_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             press_ev;

    // Two-flop synchronizer: the raw button is captured on the first flop and
    // becomes the usable value s one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign s = sync_q[1];

    // State, qualification counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    // Debounce FSM. Any disagreement of s during a CHK state drops back to the
    // previous stable state, so the next attempt restarts from a zero count.
    // The counter stops at CNT_LAST because that value always leaves the CHK
    // state, so it can never wrap. A press event fires only on the
    // PRESS_CHK->HELD edge; a bounce back from REL_CHK is not a new press.
    // The sticky flag gives set priority over the tick clear.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        press_ev = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    press_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        flag_d = press_ev | (flag_q & ~game_tick_i);
    end

    assign level   = (state_q == HELD) || (state_q == REL_CHK);
    assign press_p = flag_q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions the four raw board buttons for the block/character controller.
// Each button is synchronized and debounced, opposing directions cancel on
// the held levels, and press flags stay up until the next game tick.
//   clk, rst                      : board clock, async active-high reset
//   btn_u, btn_d, btn_l, btn_r    : raw asynchronous buttons, active-high
//   game_tick                     : slow-domain sampling strobe (1 clk wide)
//   up, down, left, right         : debounced levels with opposing-pair masking
//   up_p, down_p, left_p, right_p : sticky press flags (never masked)
// -----------------------------------------------------------------------------
module btn_conditioner
    import game_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_u,
    input  logic btn_d,
    input  logic btn_l,
    input  logic btn_r,
    input  logic game_tick,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic up_p,
    output logic down_p,
    output logic left_p,
    output logic right_p
);

    logic [NUM_DIRS-1:0] btn_vec;
    logic [NUM_DIRS-1:0] lvl_vec;
    logic [NUM_DIRS-1:0] press_vec;

    assign btn_vec[DIR_U] = btn_u;
    assign btn_vec[DIR_D] = btn_d;
    assign btn_vec[DIR_L] = btn_l;
    assign btn_vec[DIR_R] = btn_r;

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_i       (btn_vec[i]),
            .game_tick_i (game_tick),
            .level       (lvl_vec[i]),
            .press_p     (press_vec[i])
        );
    end

    // Pushing both buttons of an opposing pair means "no direction" on that
    // axis, so the controller never sees a contradictory held input.
    assign up    = lvl_vec[DIR_U] & ~lvl_vec[DIR_D];
    assign down  = lvl_vec[DIR_D] & ~lvl_vec[DIR_U];
    assign left  = lvl_vec[DIR_L] & ~lvl_vec[DIR_R];
    assign right = lvl_vec[DIR_R] & ~lvl_vec[DIR_L];

    assign up_p    = press_vec[DIR_U];
    assign down_p  = press_vec[DIR_D];
    assign left_p  = press_vec[DIR_L];
    assign right_p = press_vec[DIR_R];

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Self-checking bench for btn_conditioner with DB_CYCLES=8. A run-length
// model of each button predicts all eight outputs every cycle, and directed
// scenarios pin exact edge counts with literal expectations.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic game_tick = 1'b0;
    logic up, down, left, right, up_p, down_p, left_p, right_p;

    int compared = 0;
    int mismatched = 0;

    btn_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_u     (btn_u),
        .btn_d     (btn_d),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .game_tick (game_tick),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .up_p      (up_p),
        .down_p    (down_p),
        .left_p    (left_p),
        .right_p   (right_p)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Model state: raw samples from the last two edges (the synchronizer
    // delay), the accepted level, the count of consecutive samples that
    // disagree with it, and the sticky press flags. Index 0..3 = U,D,L,R.
    logic [3:0] rawNow;
    logic [3:0] rawPrev1, rawPrev2;
    logic [3:0] mLvl, mFlag;
    int         runLen [4];
    logic       sNow, pressEv;

    assign rawNow = {btn_r, btn_l, btn_d, btn_u};

    // A level changes once the synchronized input has disagreed with it for
    // DB+1 consecutive edges; any agreeing sample restarts the run. A 0->1
    // change is a press, which sets the flag ahead of any tick clear.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rawPrev1 = '0;
            rawPrev2 = '0;
            mLvl     = '0;
            mFlag    = '0;
            for (int i = 0; i < 4; i++) runLen[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sNow    = rawPrev2[i];
                pressEv = 1'b0;
                if (sNow != mLvl[i]) begin
                    runLen[i] = runLen[i] + 1;
                    if (runLen[i] == DB + 1) begin
                        mLvl[i]   = sNow;
                        runLen[i] = 0;
                        pressEv   = sNow;
                    end
                end else begin
                    runLen[i] = 0;
                end
                if (pressEv) mFlag[i] = 1'b1;
                else if (game_tick) mFlag[i] = 1'b0;
            end
            rawPrev2 = rawPrev1;
            rawPrev1 = rawNow;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic u, input logic d, input logic l,
                                 input logic r, input logic tick);
        btn_u     = u;
        btn_d     = d;
        btn_l     = l;
        btn_r     = r;
        game_tick = tick;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model, sampled on the
    // falling edge well away from the active edge.
    always @(negedge clk) begin
        checkOutput("model", {right_p, left_p, down_p, up_p, right, left, down, up},
                    {mFlag[3], mFlag[2], mFlag[1], mFlag[0],
                     mLvl[3] & ~mLvl[2], mLvl[2] & ~mLvl[3],
                     mLvl[1] & ~mLvl[0], mLvl[0] & ~mLvl[1]});
    end

    // Directed scenarios with hand-counted edge positions.
    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        waitEdges(3);
        checkOutput("reset_outputs", {right_p, left_p, down_p, up_p, right, left, down, up}, 8'h00);
        rst = 1'b0;
        waitEdges(1);
        checkOutput("post_reset_outputs", {right_p, left_p, down_p, up_p, right, left, down, up}, 8'h00);

        // Clean press and release on R.
        applyStimulus(0, 0, 0, 1, 0);
        waitEdges(10);
        checkOutput("r_before_edge11", {7'd0, right}, 8'd0);
        waitEdges(1);
        checkOutput("r_level_edge11", {7'd0, right}, 8'd1);
        checkOutput("r_pulse_edge11", {7'd0, right_p}, 8'd1);
        waitEdges(29);
        applyStimulus(0, 0, 0, 0, 0);
        waitEdges(10);
        checkOutput("r_release_before", {7'd0, right}, 8'd1);
        waitEdges(1);
        checkOutput("r_release_edge11", {7'd0, right}, 8'd0);
        checkOutput("r_pulse_sticky", {7'd0, right_p}, 8'd1);
        applyStimulus(0, 0, 0, 0, 1);
        waitEdges(1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("r_pulse_cleared", {7'd0, right_p}, 8'd0);

        // Bounce on U, then steady high.
        for (int i = 0; i < 10; i++) begin
            btn_u = ~i[0];
            waitEdges(3);
            checkOutput("u_bounce_quiet", {6'd0, up_p, up}, 8'd0);
        end
        btn_u = 1'b1;
        waitEdges(10);
        checkOutput("u_before_edge11", {7'd0, up}, 8'd0);
        waitEdges(1);
        checkOutput("u_level_edge11", {6'd0, up_p, up}, 8'd3);
        applyStimulus(0, 0, 0, 0, 1);
        waitEdges(1);
        applyStimulus(0, 0, 0, 0, 0);
        waitEdges(12);

        // Opposing pair L then R.
        applyStimulus(0, 0, 1, 0, 0);
        waitEdges(5);
        applyStimulus(0, 0, 1, 1, 0);
        waitEdges(6);
        checkOutput("lr_left_alone", {6'd0, right, left}, 8'b01);
        waitEdges(5);
        checkOutput("lr_both_masked", {6'd0, right, left}, 8'b00);
        checkOutput("lr_pulses", {6'd0, right_p, left_p}, 8'b11);
        applyStimulus(0, 0, 0, 0, 0);
        waitEdges(12);
        applyStimulus(0, 0, 0, 0, 1);
        waitEdges(1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("lr_pulses_cleared", {6'd0, right_p, left_p}, 8'b00);

        // Tick on the very edge D qualifies.
        applyStimulus(0, 1, 0, 0, 0);
        waitEdges(10);
        applyStimulus(0, 1, 0, 0, 1);
        waitEdges(1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("d_collision_set_wins", {6'd0, down_p, down}, 8'b11);
        waitEdges(2);
        applyStimulus(0, 1, 0, 0, 1);
        waitEdges(1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("d_next_tick_clears", {7'd0, down_p}, 8'd0);
        waitEdges(12);

        // 7-cycle glitch on D must never qualify.
        applyStimulus(0, 1, 0, 0, 0);
        waitEdges(7);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            waitEdges(1);
            checkOutput("d_glitch_quiet", {6'd0, down_p, down}, 8'd0);
        end

        // Asynchronous reset in the middle of a held press.
        applyStimulus(1, 0, 0, 0, 0);
        waitEdges(11);
        checkOutput("u_held_before_rst", {6'd0, up_p, up}, 8'b11);
        #2 rst = 1'b1;
        #1 checkOutput("u_async_rst", {6'd0, up_p, up}, 8'b00);
        waitEdges(1);
        rst = 1'b0;
        waitEdges(10);
        checkOutput("u_requal_before", {7'd0, up}, 8'd0);
        waitEdges(1);
        checkOutput("u_requal_edge11", {7'd0, up}, 8'd1);
        applyStimulus(0, 0, 0, 0, 0);
        waitEdges(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
